execute_mdu_stage: RTL

//  Parametrised RV32/64 execute stage: forwarding muxes, full RV-I ALU, branch/jump resolution, EX/MEM pipeline register.

---
 rtl/rv_ex_pkg.sv | 62 ++++++
 rtl/mdu_iter.sv | 109 ++++++++++
 rtl/execute_mdu_stage.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/rv_ex_pkg.sv
// Shared encodings for the execute stage: ALU ops, MDU/branch funct3 codes,
// forward selects and MDU sequencer states.
package rv_ex_pkg;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_AND   = 4'd2;
  localparam logic [3:0] ALU_OR    = 4'd3;
  localparam logic [3:0] ALU_XOR   = 4'd4;
  localparam logic [3:0] ALU_SLL   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_SLT   = 4'd8;
  localparam logic [3:0] ALU_SLTU  = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  localparam logic [2:0] BR_EQ  = 3'b000;
  localparam logic [2:0] BR_NE  = 3'b001;
  localparam logic [2:0] BR_LT  = 3'b100;
  localparam logic [2:0] BR_GE  = 3'b101;
  localparam logic [2:0] BR_LTU = 3'b110;
  localparam logic [2:0] BR_GEU = 3'b111;

  localparam logic [1:0] FWD_RF   = 2'b00;
  localparam logic [1:0] FWD_W    = 2'b01;
  localparam logic [1:0] FWD_M    = 2'b10;
  localparam logic [1:0] FWD_ZERO = 2'b11;

  localparam logic [1:0] MDU_IDLE = 2'd0;
  localparam logic [1:0] MDU_RUN  = 2'd1;
  localparam logic [1:0] MDU_DONE = 2'd2;

  typedef struct packed {
    logic neg_q;
    logic neg_r;
    logic div0;
  } mdu_sign_t;

  function automatic logic md_sign_a(input logic [2:0] f3);
    case (f3)
      MD_MULH, MD_MULHSU, MD_DIV, MD_REM: md_sign_a = 1'b1;
      default:                            md_sign_a = 1'b0;
    endcase
  endfunction

  function automatic logic md_sign_b(input logic [2:0] f3);
    case (f3)
      MD_MULH, MD_DIV, MD_REM: md_sign_b = 1'b1;
      default:                 md_sign_b = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mdu_iter.sv
// Iterative RV-M unit: one shift-add or restoring-subtract step per cycle on
// operand magnitudes, sign-corrected in the DONE cycle.
module mdu_iter
  import rv_ex_pkg::*;
#(
  parameter int XLEN = 32,
  localparam int SHW = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_flush,
  input  logic            i_start,
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic            o_stall,
  output logic            o_done,
  output logic [XLEN-1:0] o_result
);

  logic [1:0]      r_state;
  logic [SHW-1:0]  r_cnt;
  logic [XLEN-1:0] r_hi, r_lo, r_m;
  logic [2:0]      r_op;
  mdu_sign_t       r_sign;

  logic              w_neg_a, w_neg_b, w_start;
  logic [XLEN-1:0]   w_mag_a, w_mag_b, w_quo, w_rem;
  logic [XLEN:0]     w_mul_sum, w_div_sh, w_div_diff;
  logic [2*XLEN-1:0] w_prod, w_prod_s;

  // Operand magnitudes, per-step datapath and final sign correction.
  always_comb begin
    w_neg_a    = md_sign_a(i_funct3) & i_a[XLEN-1];
    w_neg_b    = md_sign_b(i_funct3) & i_b[XLEN-1];
    w_mag_a    = w_neg_a ? ({XLEN{1'b0}} - i_a) : i_a;
    w_mag_b    = w_neg_b ? ({XLEN{1'b0}} - i_b) : i_b;
    w_start    = (r_state == MDU_IDLE) & i_start & ~i_flush;
    o_stall    = w_start | ((r_state == MDU_RUN) & ~i_flush);
    o_done     = (r_state == MDU_DONE) & ~i_flush;
    w_mul_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_m} : {(XLEN+1){1'b0}});
    w_div_sh   = {r_hi, r_lo[XLEN-1]};
    w_div_diff = w_div_sh - {1'b0, r_m};
    w_prod     = {r_hi, r_lo};
    w_prod_s   = r_sign.neg_q ? ({(2*XLEN){1'b0}} - w_prod) : w_prod;
    // Divide-by-zero quotient is all-ones whatever the operand signs.
    if (r_sign.div0) begin
      w_quo = {XLEN{1'b1}};
    end else begin
      w_quo = r_sign.neg_q ? ({XLEN{1'b0}} - r_lo) : r_lo;
    end
    w_rem = r_sign.neg_r ? ({XLEN{1'b0}} - r_hi) : r_hi;
    case (r_op)
      MD_MUL:                       o_result = w_prod_s[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: o_result = w_prod_s[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:              o_result = w_quo;
      MD_REM, MD_REMU:              o_result = w_rem;
      default:                      o_result = {XLEN{1'b0}};
    endcase
  end

  // Sequencer and working registers; flush always returns to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= MDU_IDLE;
      r_cnt   <= {SHW{1'b0}};
      r_hi    <= {XLEN{1'b0}};
      r_lo    <= {XLEN{1'b0}};
      r_m     <= {XLEN{1'b0}};
      r_op    <= 3'd0;
      r_sign  <= '0;
    end else if (i_flush) begin
      r_state <= MDU_IDLE;
    end else begin
      case (r_state)
        MDU_IDLE: begin
          if (i_start) begin
            r_state      <= MDU_RUN;
            r_cnt        <= SHW'(XLEN - 1);
            r_op         <= i_funct3;
            r_hi         <= {XLEN{1'b0}};
            r_lo         <= i_funct3[2] ? w_mag_a : w_mag_b;
            r_m          <= i_funct3[2] ? w_mag_b : w_mag_a;
            r_sign.neg_q <= w_neg_a ^ w_neg_b;
            r_sign.neg_r <= w_neg_a;
            r_sign.div0  <= i_funct3[2] & (i_b == {XLEN{1'b0}});
          end
        end
        MDU_RUN: begin
          if (r_op[2]) begin
            r_hi <= w_div_diff[XLEN] ? w_div_sh[XLEN-1:0] : w_div_diff[XLEN-1:0];
            r_lo <= {r_lo[XLEN-2:0], ~w_div_diff[XLEN]};
          end else begin
            r_hi <= w_mul_sum[XLEN:1];
            r_lo <= {w_mul_sum[0], r_lo[XLEN-1:1]};
          end
          if (r_cnt == {SHW{1'b0}}) begin
            r_state <= MDU_DONE;
          end else begin
            r_cnt <= r_cnt - SHW'(1);
          end
        end
        MDU_DONE: r_state <= MDU_IDLE;
        default:  r_state <= MDU_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/execute_mdu_stage.sv
// RV32/64 execute stage: forwarding, ALU, branch/jump resolution, optional
// iterative MDU and the EX/MEM pipeline register.
module execute_mdu_stage
  import rv_ex_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter bit MDU_EN = 1'b1,
  localparam int SHW   = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush_e,
  input  logic            regwrite_e,
  input  logic            memrw_e,
  input  logic            branch_e,
  input  logic            jump_e,
  input  logic            jalr_e,
  input  logic            brun_e,
  input  logic            asel_e,
  input  logic            bsel_e,
  input  logic            md_e,
  input  logic [2:0]      funct3_e,
  input  logic [1:0]      wbsel_e,
  input  logic [3:0]      alusel_e,
  input  logic [1:0]      fwd_a_e,
  input  logic [1:0]      fwd_b_e,
  input  logic [4:0]      rd_e,
  input  logic [XLEN-1:0] rd1_e,
  input  logic [XLEN-1:0] rd2_e,
  input  logic [XLEN-1:0] imm_e,
  input  logic [XLEN-1:0] pc_e,
  input  logic [XLEN-1:0] pc4_e,
  input  logic [XLEN-1:0] result_w,
  output logic            stall_e,
  output logic            pcsel_e,
  output logic [XLEN-1:0] pc_target_e,
  output logic            regwrite_m,
  output logic            memrw_m,
  output logic [1:0]      wbsel_m,
  output logic [2:0]      funct3_m,
  output logic [4:0]      rd_m,
  output logic [XLEN-1:0] alures_m,
  output logic [XLEN-1:0] data_write_m,
  output logic [XLEN-1:0] pc4_m
);

  logic [XLEN-1:0] w_fwd_a, w_fwd_b, w_src_a, w_src_b, w_alu_res, w_mdu_res;
  logic [SHW-1:0]  w_shamt;
  logic            w_lt, w_cond, w_mdu_stall, w_mdu_done;

  // Operand forwarding, ALU and branch condition.
  always_comb begin
    case (fwd_a_e)
      FWD_RF:  w_fwd_a = rd1_e;
      FWD_W:   w_fwd_a = result_w;
      FWD_M:   w_fwd_a = alures_m;
      default: w_fwd_a = {XLEN{1'b0}};
    endcase
    case (fwd_b_e)
      FWD_RF:  w_fwd_b = rd2_e;
      FWD_W:   w_fwd_b = result_w;
      FWD_M:   w_fwd_b = alures_m;
      default: w_fwd_b = {XLEN{1'b0}};
    endcase
    w_src_a = asel_e ? pc_e : w_fwd_a;
    w_src_b = bsel_e ? imm_e : w_fwd_b;
    w_shamt = w_src_b[SHW-1:0];
    case (alusel_e)
      ALU_ADD:   w_alu_res = w_src_a + w_src_b;
      ALU_SUB:   w_alu_res = w_src_a - w_src_b;
      ALU_AND:   w_alu_res = w_src_a & w_src_b;
      ALU_OR:    w_alu_res = w_src_a | w_src_b;
      ALU_XOR:   w_alu_res = w_src_a ^ w_src_b;
      ALU_SLL:   w_alu_res = w_src_a << w_shamt;
      ALU_SRL:   w_alu_res = w_src_a >> w_shamt;
      ALU_SRA:   w_alu_res = $unsigned($signed(w_src_a) >>> w_shamt);
      ALU_SLT:   w_alu_res = {{(XLEN-1){1'b0}}, $signed(w_src_a) < $signed(w_src_b)};
      ALU_SLTU:  w_alu_res = {{(XLEN-1){1'b0}}, w_src_a < w_src_b};
      ALU_PASSB: w_alu_res = w_src_b;
      default:   w_alu_res = {XLEN{1'b0}};
    endcase
    // LTU/GEU codes are unsigned regardless of brun_e.
    w_lt = (brun_e | funct3_e[1]) ? (w_fwd_a < w_fwd_b)
                                  : ($signed(w_fwd_a) < $signed(w_fwd_b));
    case (funct3_e)
      BR_EQ:          w_cond = (w_fwd_a == w_fwd_b);
      BR_NE:          w_cond = (w_fwd_a != w_fwd_b);
      BR_LT, BR_LTU:  w_cond = w_lt;
      BR_GE, BR_GEU:  w_cond = ~w_lt;
      default:        w_cond = 1'b0;
    endcase
    stall_e     = w_mdu_stall;
    pcsel_e     = ~flush_e & ~stall_e & ((branch_e & w_cond) | jump_e);
    pc_target_e = jalr_e ? ((w_fwd_a + imm_e) & {{(XLEN-1){1'b1}}, 1'b0})
                         : (pc_e + imm_e);
  end

  if (MDU_EN) begin : g_mdu
    mdu_iter #(.XLEN(XLEN)) u_mdu (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_flush  (flush_e),
      .i_start  (md_e),
      .i_funct3 (funct3_e),
      .i_a      (w_fwd_a),
      .i_b      (w_fwd_b),
      .o_stall  (w_mdu_stall),
      .o_done   (w_mdu_done),
      .o_result (w_mdu_res)
    );
  end else begin : g_no_mdu
    assign w_mdu_stall = 1'b0;
    assign w_mdu_done  = 1'b0;
    assign w_mdu_res   = {XLEN{1'b0}};
  end

  // EX/MEM register; stall or flush inserts a bubble and holds the data fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regwrite_m   <= 1'b0;
      memrw_m      <= 1'b0;
      wbsel_m      <= 2'd0;
      funct3_m     <= 3'd0;
      rd_m         <= 5'd0;
      alures_m     <= {XLEN{1'b0}};
      data_write_m <= {XLEN{1'b0}};
      pc4_m        <= {XLEN{1'b0}};
    end else if (flush_e | stall_e) begin
      regwrite_m <= 1'b0;
      memrw_m    <= 1'b0;
    end else begin
      regwrite_m   <= regwrite_e;
      memrw_m      <= memrw_e;
      wbsel_m      <= wbsel_e;
      funct3_m     <= funct3_e;
      rd_m         <= rd_e;
      alures_m     <= w_mdu_done ? w_mdu_res : w_alu_res;
      data_write_m <= w_fwd_b;
      pc4_m        <= pc4_e;
    end
  end

endmodule
